prefix_adder: RTL and testbench

Registered, parameterizable parallel-prefix (Kogge-Stone) unsigned adder. It adds two WIDTH-bit operands with no carry-in and presents the WIDTH+1-bit sum, carry included as the MSB, from an output register one clock after sampling. It serves as the fast-carry arithmetic primitive for datapath blocks and is the standalone unit under test for prefix-adder verification.

---
 rtl/prefix_adder_pkg.sv | 17 +
 rtl/prefix_adder_cell.sv | 26 ++
 rtl/prefix_adder.sv | 81 ++++++++
 tb/tb_prefix_adder.sv | 131 +++++++++++++
 4 files changed

// File: rtl/prefix_adder_pkg.sv
// Shared constants for the Kogge-Stone prefix adder: default operand width
// and the prefix level count.
package prefix_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Smallest n with 2**n >= w, i.e. the number of prefix levels.
    function automatic int prefix_levels(input int w);
        int r;
        r = 0;
        for (int i = 30; i >= 0; i--) begin
            if ((1 << i) >= w) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/prefix_adder_cell.sv
// Kogge-Stone prefix operator. A black cell produces group generate and propagate.
// A gray cell produces group generate only, and drives P to 0.
module prefix_cell #(
    parameter bit BLACK = 1'b1
) (
    input  logic G_hi,
    input  logic P_hi,
    input  logic G_lo,
    input  logic P_lo,
    output logic G,
    output logic P
);

    assign G = G_hi | (P_hi & G_lo);

    generate
        if (BLACK) begin : g_black
            assign P = P_hi & P_lo;
        end else begin : g_gray
            logic unused_p_lo;
            assign unused_p_lo = P_lo;
            assign P = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/prefix_adder.sv
// Registered WIDTH-bit unsigned Kogge-Stone adder. The result is WIDTH+1 bits with the carry in the MSB.
// Latency is one cycle, and an asynchronous active-low reset clears the output register.
module prefix_adder
    import prefix_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic [WIDTH:0]   o
);

    localparam int LEVELS = prefix_levels(WIDTH);

    logic [WIDTH-1:0] g0, p0;
    logic [WIDTH-1:0] g_fin;
    logic [WIDTH:0]   carry;
    logic [WIDTH:0]   sum_d, sum_q;

    assign g0 = i0 & i1;
    assign p0 = i0 ^ i1;

    // Level lvl has span 2**(lvl-1). A cell is gray when its low operand already
    // reaches bit 0, because that group's propagate is never consumed without a carry-in.
    genvar lvl, k;
    generate
        for (lvl = LEVELS; lvl > 0; lvl = lvl - 1) begin : g_lvl
            localparam int D = 1 << (lvl - 1);
            logic [WIDTH-1:0] g_prev, p_prev, g_n, p_n;
            logic unused_p_n;

            if (lvl == 1) begin : g_src0
                assign g_prev = g0;
                assign p_prev = p0;
            end else begin : g_srcn
                assign g_prev = g_lvl[lvl-1].g_n;
                assign p_prev = g_lvl[lvl-1].p_n;
            end

            for (k = WIDTH; k > 0; k = k - 1) begin : g_bit
                localparam int B = k - 1;
                if (B >= D) begin : g_cell
                    prefix_cell #(
                        .BLACK(B >= 2 * D)
                    ) u_cell (
                        .G_hi(g_prev[B]),
                        .P_hi(p_prev[B]),
                        .G_lo(g_prev[B-D]),
                        .P_lo(p_prev[B-D]),
                        .G   (g_n[B]),
                        .P   (p_n[B])
                    );
                end else begin : g_pass
                    assign g_n[B] = g_prev[B];
                    assign p_n[B] = p_prev[B];
                end
            end

            assign unused_p_n = ^p_n;
        end
    endgenerate

    assign g_fin = g_lvl[LEVELS].g_n;

    // Carry into bit k is the group generate of bits 0..k-1. There is no carry-in.
    assign carry = {g_fin, 1'b0};
    assign sum_d = {carry[WIDTH], p0 ^ carry[WIDTH-1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign o = sum_q;

endmodule

// File: tb/tb_prefix_adder.sv
// Directed and sweep bench for prefix_adder at WIDTH 8, 16 and 13.
module tb_prefix_adder;
    import prefix_adder_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [7:0]  a8,  b8;
    logic [15:0] a16, b16;
    logic [12:0] a13, b13;
    logic [8:0]  o8;
    logic [16:0] o16;
    logic [13:0] o13;

    int n_tests;
    int n_fail;

    prefix_adder #(.WIDTH(8))  dut8  (.clk(clk), .reset(rst_n), .i0(a8),  .i1(b8),  .o(o8));
    prefix_adder #(.WIDTH(16)) dut16 (.clk(clk), .reset(rst_n), .i0(a16), .i1(b16), .o(o16));
    prefix_adder #(.WIDTH(13)) dut13 (.clk(clk), .reset(rst_n), .i0(a13), .i1(b13), .o(o13));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] va [8] = '{8'h01, 8'h01, 8'hFF, 8'hFF, 8'hAF, 8'hF1, 8'hCC, 8'hFF};
    logic [7:0] vb [8] = '{8'h00, 8'h01, 8'h01, 8'hFF, 8'hFA, 8'hF9, 8'hBB, 8'h00};
    logic [8:0] vs [8] = '{9'h001, 9'h002, 9'h100, 9'h1FE, 9'h1A9, 9'h1EA, 9'h187, 9'h0FF};

    initial begin
        logic [63:0] t;
        logic [63:0] exp8, exp16, exp13;
        n_tests = 0;
        n_fail  = 0;

        check_eq("lvl_w2",  64'(prefix_levels(2)),  64'd1);
        check_eq("lvl_w8",  64'(prefix_levels(8)),  64'd3);
        check_eq("lvl_w13", 64'(prefix_levels(13)), 64'd4);
        check_eq("lvl_w16", 64'(prefix_levels(16)), 64'd4);
        check_eq("lvl_w64", 64'(prefix_levels(64)), 64'd6);

        rst_n = 1'b0;
        a8 = 8'hFF;  b8 = 8'hFF;
        a16 = '1;    b16 = '1;
        a13 = '1;    b13 = '1;
        #1;
        check_eq("rst_init8", 64'(o8), 64'h0);
        repeat (3) begin
            @(posedge clk); #1;
            check_eq("rst_hold8",  64'(o8),  64'h0);
            check_eq("rst_hold16", 64'(o16), 64'h0);
            check_eq("rst_hold13", 64'(o13), 64'h0);
        end

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a8 = va[i]; b8 = vb[i];
            @(posedge clk); #1;
            check_eq($sformatf("dir%0d", i), 64'(o8), 64'(vs[i]));
        end

        for (int k = 0; k <= 16; k++) begin
            t = (64'd1 << k) - 64'd1;
            a8 = t[7:0];    b8 = 8'd1;
            a16 = t[15:0];  b16 = 16'd1;
            a13 = t[12:0];  b13 = 13'd1;
            @(posedge clk); #1;
            if (k <= 8)  check_eq($sformatf("carry8_k%0d", k),  64'(o8),  64'd1 << k);
            if (k <= 13) check_eq($sformatf("carry13_k%0d", k), 64'(o13), 64'd1 << k);
            check_eq($sformatf("carry16_k%0d", k), 64'(o16), 64'd1 << k);
        end

        // Back-to-back operands, with glitches between edges.
        a8 = 8'($urandom); b8 = 8'($urandom);
        for (int i = 0; i < 20; i++) begin
            exp8 = 64'(a8) + 64'(b8);
            @(posedge clk); #1;
            check_eq($sformatf("lat%0d", i), 64'(o8), exp8);
            a8 = 8'($urandom); b8 = 8'($urandom);
            #2;
            check_eq($sformatf("glitch%0d", i), 64'(o8), exp8);
            a8 = 8'($urandom); b8 = 8'($urandom);
        end

        a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk); #1;
        check_eq("pre_arst", 64'(o8), 64'h1FE);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_async", 64'(o8), 64'h0);
        repeat (2) begin
            @(posedge clk); #1;
            check_eq("arst_hold", 64'(o8), 64'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a8 = 8'h01; b8 = 8'h01;
        @(posedge clk); #1;
        check_eq("post_rel", 64'(o8), 64'h002);

        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                a8 = a[7:0]; b8 = b[7:0];
                @(posedge clk); #1;
                check_eq("exh8", 64'(o8), 64'(a) + 64'(b));
            end
        end

        for (int i = 0; i < 2000; i++) begin
            a16 = 16'($urandom); b16 = 16'($urandom);
            a13 = 13'($urandom); b13 = 13'($urandom);
            exp16 = 64'(a16) + 64'(b16);
            exp13 = 64'(a13) + 64'(b13);
            @(posedge clk); #1;
            check_eq("rnd16", 64'(o16), exp16);
            check_eq("rnd13", 64'(o13), exp13);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
